// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU command sequencer:
//   - DW / OPW   : data width (4) and opcode width (3)
//   - OP_*       : opcode encodings understood by the sequencer and the ALU
//   - state_t    : sequencer FSM encoding (S_IDLE, S_ISSUE, S_DONE)
//   - is_arith() : true for opcodes whose ALU carry/borrow is meaningful
package alu_seq_pkg;

  localparam int DW  = 4;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD  = 3'b000;
  localparam logic [OPW-1:0] OP_SUB  = 3'b001;
  localparam logic [OPW-1:0] OP_LOAD = 3'b010;
  localparam logic [OPW-1:0] OP_ILL  = 3'b011;
  localparam logic [OPW-1:0] OP_AND  = 3'b100;
  localparam logic [OPW-1:0] OP_OR   = 3'b101;
  localparam logic [OPW-1:0] OP_XOR  = 3'b110;
  localparam logic [OPW-1:0] OP_NOR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the command handshake and the ALU operand/result bus.
//   slave  : sequencer view (takes commands, drives the ALU operands)
//   master : environment view (command source plus the peer ALU)
//   Signals:
//     cmd_valid/cmd_op/cmd_data/cmd_ready : command handshake
//     alu_a/alu_b/alu_op                  : operands and opcode to the ALU
//     alu_result/alu_overflow             : ALU result and carry/borrow out
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic           cmd_valid;
  logic [OPW-1:0] cmd_op;
  logic [DW-1:0]  cmd_data;
  logic           cmd_ready;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_result;
  logic           alu_overflow;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_result, alu_overflow,
    output cmd_ready, alu_a, alu_b, alu_op
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_result, alu_overflow,
    input  cmd_ready, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accumulator-style command sequencer in front of a combinational 4-bit
//   ALU. Each accepted command spends one cycle in ISSUE (ALU operands
//   presented, result captured at the closing edge) and one in DONE
//   (completion pulse), giving a fixed 3-cycle command period.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     bus (slave)   : command handshake and ALU operand/result bus
//     acc           : accumulator
//     ovf           : overflow of the last completed command
//     res_valid     : one-cycle completion pulse
//     err           : one-cycle pulse for the illegal opcode
//   Optional (ALU_SEQ_STICKY_OVF_EN defined):
//     ovf_clr       : clears ovf_sticky
//     ovf_sticky    : set by any completed ADD/SUB that overflowed
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [DW-1:0]       acc,
  output logic                ovf,
  output logic                res_valid,
  output logic                err
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  input  logic                ovf_clr,
  output logic                ovf_sticky
`endif
);

  state_t         state_reg;
  logic           cmd_ready_reg;
  logic [DW-1:0]  alu_a_reg;
  logic [DW-1:0]  alu_b_reg;
  logic [OPW-1:0] alu_op_reg;
  logic [DW-1:0]  acc_reg;
  logic           ovf_reg;
  logic           res_valid_reg;
  logic           err_reg;

  // alu_b_reg / alu_op_reg double as the latched command; they keep their
  // value after ISSUE so the ALU inputs stay stable between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cmd_ready_reg <= 1'b1;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_reg     <= acc_reg;
            alu_b_reg     <= bus.cmd_data;
            alu_op_reg    <= bus.cmd_op;
            cmd_ready_reg <= 1'b0;
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (alu_op_reg)
            OP_LOAD: begin
              acc_reg <= alu_b_reg;
              ovf_reg <= 1'b0;
            end
            OP_ILL: begin
              // Illegal command leaves accumulator and flag untouched.
            end
            OP_ADD, OP_SUB: begin
              acc_reg <= bus.alu_result;
              ovf_reg <= bus.alu_overflow;
            end
            default: begin
              acc_reg <= bus.alu_result;
              ovf_reg <= 1'b0;
            end
          endcase
          res_valid_reg <= (alu_op_reg != OP_ILL);
          err_reg       <= (alu_op_reg == OP_ILL);
          state_reg     <= S_DONE;
        end
        S_DONE: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end
        default: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic ovf_sticky_reg;

  // A set in the same cycle as a clear wins, so no overflow is ever missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_reg <= 1'b0;
    end else if (state_reg == S_ISSUE && is_arith(alu_op_reg) && bus.alu_overflow) begin
      ovf_sticky_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_sticky_reg;
`endif

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_op    = alu_op_reg;
  assign acc           = acc_reg;
  assign ovf           = ovf_reg;
  assign res_valid     = res_valid_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer with a behavioural 4-bit ALU as the
//   peer instance. Define ALU_SEQ_STICKY_OVF_EN to include the sticky flag.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic          clk;
  logic          rst;
  logic [DW-1:0] acc;
  logic          ovf;
  logic          res_valid;
  logic          err;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic          ovf_clr;
  logic          ovf_sticky;
`endif

  int pass_cnt;
  int total_cnt;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .acc       (acc),
    .ovf       (ovf),
    .res_valid (res_valid),
    .err       (err)
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

  // Peer combinational ALU
  logic [DW:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (bus.alu_op)
      3'b000: alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: alu_wide = {(bus.alu_a < bus.alu_b), bus.alu_a - bus.alu_b};
      3'b100: alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      3'b101: alu_wide = {1'b0, bus.alu_a | bus.alu_b};
      3'b110: alu_wide = {1'b0, bus.alu_a ^ bus.alu_b};
      3'b111: alu_wide = {1'b0, ~(bus.alu_a | bus.alu_b)};
      default: alu_wide = '0;
    endcase
    bus.alu_result   = alu_wide[DW-1:0];
    bus.alu_overflow = alu_wide[DW];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Issue one command from IDLE and check every cycle of its lifetime.
  task automatic do_cmd(input string name, input logic [2:0] op, input logic [3:0] data,
                        input logic [3:0] exp_acc, input logic exp_ovf, input logic exp_err);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b111;
    bus.cmd_data  = 4'h0;
    check({name, " issue cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({name, " issue alu_b"}, 32'(bus.alu_b), 32'(data));
    check({name, " issue alu_op"}, 32'(bus.alu_op), 32'(op));
    step();
    check({name, " done acc"}, 32'(acc), 32'(exp_acc));
    check({name, " done ovf"}, 32'(ovf), 32'(exp_ovf));
    check({name, " done res_valid"}, 32'(res_valid), 32'(!exp_err));
    check({name, " done err"}, 32'(err), 32'(exp_err));
    check({name, " done cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    step();
    check({name, " idle res_valid"}, 32'(res_valid), 32'd0);
    check({name, " idle err"}, 32'(err), 32'd0);
    check({name, " idle cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    $display("cmd %s op=%0d data=%0h -> acc=%0h ovf=%0b res_valid/err seen", name, op, data, acc, ovf);
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 4'h0;
`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr       = 1'b0;
`endif

    // Reset state
    step();
    step();
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset acc", 32'(acc), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset alu_a", 32'(bus.alu_a), 32'd0);
    rst = 1'b0;
    $display("reset released");

    // ADD carry and plain ADD
    do_cmd("load9", OP_LOAD, 4'h9, 4'h9, 1'b0, 1'b0);
    do_cmd("add8",  OP_ADD,  4'h8, 4'h1, 1'b1, 1'b0);
    do_cmd("add2",  OP_ADD,  4'h2, 4'h3, 1'b0, 1'b0);

    // SUB borrow and plain SUB
    do_cmd("load3", OP_LOAD, 4'h3, 4'h3, 1'b0, 1'b0);
    do_cmd("sub5",  OP_SUB,  4'h5, 4'hE, 1'b1, 1'b0);
    do_cmd("sub4",  OP_SUB,  4'h4, 4'hA, 1'b0, 1'b0);

    // Logic ops
    do_cmd("loadA", OP_LOAD, 4'hA, 4'hA, 1'b0, 1'b0);
    do_cmd("and6",  OP_AND,  4'h6, 4'h2, 1'b0, 1'b0);
    do_cmd("or1",   OP_OR,   4'h1, 4'h3, 1'b0, 1'b0);
    do_cmd("xorF",  OP_XOR,  4'hF, 4'hC, 1'b0, 1'b0);
    do_cmd("nor0",  OP_NOR,  4'h0, 4'h3, 1'b0, 1'b0);

    // Illegal opcode
    do_cmd("load5", OP_LOAD, 4'h5, 4'h5, 1'b0, 1'b0);
    do_cmd("ill7",  OP_ILL,  4'h7, 4'h5, 1'b0, 1'b1);
    check("ill hold alu_b", 32'(bus.alu_b), 32'h7);

    // Back-to-back ADD 1 with reset during the third command's ISSUE
    do_cmd("load0", OP_LOAD, 4'h0, 4'h0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 4'h1;
    step();                       // cmd1 in ISSUE
    step();                       // cmd1 DONE
    check("b2b c1 acc", 32'(acc), 32'd1);
    check("b2b c1 res_valid", 32'(res_valid), 32'd1);
    step();                       // IDLE
    check("b2b idle1 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();                       // cmd2 in ISSUE
    check("b2b c2 issue cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("b2b c2 issue alu_a", 32'(bus.alu_a), 32'd1);
    step();                       // cmd2 DONE
    check("b2b c2 acc", 32'(acc), 32'd2);
    check("b2b c2 res_valid", 32'(res_valid), 32'd1);
    step();                       // IDLE
    step();                       // cmd3 in ISSUE
    check("b2b c3 issue alu_a", 32'(bus.alu_a), 32'd2);
    rst = 1'b1;
    step();                       // reset edge
    rst = 1'b0;
    check("b2b rst acc", 32'(acc), 32'd0);
    check("b2b rst res_valid", 32'(res_valid), 32'd0);
    check("b2b rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("b2b rst ovf", 32'(ovf), 32'd0);
    step();                       // cmd4 in ISSUE
    bus.cmd_valid = 1'b0;
    check("b2b c4 issue cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("b2b c4 issue res_valid", 32'(res_valid), 32'd0);
    step();                       // cmd4 DONE
    check("b2b c4 acc", 32'(acc), 32'd1);
    check("b2b c4 res_valid", 32'(res_valid), 32'd1);
    step();
    check("b2b end cmd_ready", 32'(bus.cmd_ready), 32'd1);
    $display("back-to-back with reset: acc=%0h", acc);

`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("sticky pre-clear", 32'(ovf_sticky), 32'd0);
    do_cmd("s_load9", OP_LOAD, 4'h9, 4'h9, 1'b0, 1'b0);
    check("sticky after load", 32'(ovf_sticky), 32'd0);
    do_cmd("s_add8",  OP_ADD,  4'h8, 4'h1, 1'b1, 1'b0);
    check("sticky after add ovf", 32'(ovf_sticky), 32'd1);
    do_cmd("s_andF",  OP_AND,  4'hF, 4'h1, 1'b0, 1'b0);
    check("sticky after and", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("sticky cleared", 32'(ovf_sticky), 32'd0);
    $display("sticky overflow sequence done");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
